// File: rtl/phy_rx_lane_deskew.sv
// rtl/phy_rx_lane_deskew.sv - serial comma aligner, lock detector and round-robin lane striper
module phy_rx_lane_deskew #(
  parameter int              WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA     = 8'hBC,
  parameter int              LOCK_COUNT = 4,
  parameter int              LANES      = 4,
  localparam int             LP_W       = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  output logic                   active,
  output logic [LP_W-1:0]        lane_ptr
);

  localparam int CW = $clog2(WIDTH);
  localparam int NW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {SEARCH, COUNT, LOCKED} state_t;

  state_t                 state, state_d;
  logic [WIDTH-1:0]       sr, sr_next;
  logic [CW-1:0]          bit_cnt, bit_cnt_d;
  logic [NW-1:0]          comma_cnt, comma_cnt_d;
  logic                   active_d;
  logic [LP_W-1:0]        lane_ptr_d;
  logic [LANES*WIDTH-1:0] out_data_d;
  logic [LANES-1:0]       out_valid_d;
  logic                   is_comma, boundary;

  always_comb begin
    sr_next     = {sr[WIDTH-2:0], in};
    is_comma    = (sr_next == COMMA);
    boundary    = (bit_cnt == CW'(WIDTH - 1));
    state_d     = state;
    bit_cnt_d   = boundary ? '0 : bit_cnt + CW'(1);
    comma_cnt_d = comma_cnt;
    active_d    = active;
    lane_ptr_d  = lane_ptr;
    out_data_d  = out_data;
    out_valid_d = '0;

    case (state)
      SEARCH: begin
        bit_cnt_d = '0;
        if (is_comma) begin
          comma_cnt_d = NW'(1);
          if (LOCK_COUNT == 1) begin
            state_d    = LOCKED;
            active_d   = 1'b1;
            lane_ptr_d = '0;
          end else begin
            state_d = COUNT;
          end
        end
      end

      COUNT, LOCKED: begin
        // A comma off the symbol grid means the line slipped; it wins over any partial symbol.
        if (is_comma && !boundary) begin
          state_d     = COUNT;
          bit_cnt_d   = '0;
          comma_cnt_d = NW'(1);
          active_d    = 1'b0;
          lane_ptr_d  = '0;
        end else if (boundary) begin
          if (state == COUNT) begin
            if (is_comma) begin
              if (int'(comma_cnt) + 1 >= LOCK_COUNT) begin
                state_d     = LOCKED;
                comma_cnt_d = NW'(LOCK_COUNT);
                active_d    = 1'b1;
                lane_ptr_d  = '0;
              end else begin
                comma_cnt_d = comma_cnt + NW'(1);
              end
            end else begin
              state_d     = SEARCH;
              comma_cnt_d = '0;
            end
          end else if (!is_comma) begin
            out_data_d[lane_ptr*WIDTH +: WIDTH] = sr_next;
            out_valid_d[lane_ptr]               = 1'b1;
            lane_ptr_d = (LANES == 1) ? '0 : lane_ptr + LP_W'(1);
          end
        end
      end

      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      sr        <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      active    <= 1'b0;
      lane_ptr  <= '0;
      out_data  <= '0;
      out_valid <= '0;
    end else begin
      state     <= state_d;
      sr        <= sr_next;
      bit_cnt   <= bit_cnt_d;
      comma_cnt <= comma_cnt_d;
      active    <= active_d;
      lane_ptr  <= lane_ptr_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_phy_rx_lane_deskew.sv
// tb/tb_phy_rx_lane_deskew.sv - scoreboard bench for phy_rx_lane_deskew with a bit-stream reference model
module tb_phy_rx_lane_deskew;

  localparam int         WIDTH      = 8;
  localparam logic [7:0] COMMA      = 8'hBC;
  localparam int         LOCK_COUNT = 4;
  localparam int         LANES      = 4;
  localparam int         LP_W       = 2;

  logic                   clk   = 1'b0;
  logic                   reset = 1'b1;
  logic                   in    = 1'b0;
  logic [LANES*WIDTH-1:0] out_data;
  logic [LANES-1:0]       out_valid;
  logic                   active;
  logic [LP_W-1:0]        lane_ptr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  phy_rx_lane_deskew #(
    .WIDTH(WIDTH), .COMMA(COMMA), .LOCK_COUNT(LOCK_COUNT), .LANES(LANES)
  ) dut (
    .clk(clk), .reset(reset), .in(in),
    .out_data(out_data), .out_valid(out_valid), .active(active), .lane_ptr(lane_ptr)
  );

  typedef struct {bit act; int lp; int vlane; bit chk_zero;} st_t;
  typedef struct {int lane; int data;} sym_t;
  st_t  st_q[$];
  sym_t sym_q[$];

  // Reference: alignment is the bit index of the last accepted comma; symbols end every WIDTH bits after it.
  int m_win, m_anchor, m_commas, m_lane, m_t;
  bit m_locked;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit b, input bit r, input bit chk);
    st_t  s;
    sym_t d;
    int   vl;
    bit   bnd;
    vl = -1;
    if (r) begin
      m_win = 0; m_anchor = -1; m_commas = 0; m_locked = 0; m_lane = 0;
    end else begin
      m_win = ((m_win << 1) | int'(b)) & ((1 << WIDTH) - 1);
      if (m_anchor < 0) begin
        if (m_win == int'(COMMA)) begin
          m_anchor = m_t; m_commas = 1;
          if (LOCK_COUNT == 1) begin m_locked = 1; m_lane = 0; end
        end
      end else begin
        bnd = ((m_t - m_anchor) % WIDTH) == 0;
        if (m_win == int'(COMMA) && !bnd) begin
          m_anchor = m_t; m_commas = 1; m_locked = 0; m_lane = 0;
        end else if (bnd) begin
          if (!m_locked) begin
            if (m_win == int'(COMMA)) begin
              m_commas++;
              if (m_commas >= LOCK_COUNT) begin m_locked = 1; m_lane = 0; end
            end else begin
              m_anchor = -1; m_commas = 0;
            end
          end else if (m_win != int'(COMMA)) begin
            d.lane = m_lane; d.data = m_win;
            sym_q.push_back(d);
            vl = m_lane;
            m_lane = (m_lane + 1) % LANES;
          end
        end
      end
    end
    s.act = m_locked; s.lp = m_lane; s.vlane = vl; s.chk_zero = chk;
    st_q.push_back(s);
    m_t++;
  endtask

  task automatic send_bit(input bit b, input bit r = 1'b0, input bit chk = 1'b0);
    in = b;
    reset = r;
    @(posedge clk);
    model_step(b, r, chk || r);
    #1;
  endtask

  task automatic send_sym(input logic [7:0] v, input bit chk = 1'b0);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(v[i], 1'b0, chk);
  endtask

  task automatic send_stream();
    logic [7:0] data [8];
    data = '{8'hFF, 8'hDD, 8'hEE, 8'hCC, 8'hBB, 8'h99, 8'hAA, 8'h88};
    for (int i = 0; i < 5; i++) send_sym(COMMA);
    check("active_after_5bc", active, 1);
    for (int i = 0; i < 8; i++) send_sym(data[i]);
    check("final_lanes", out_data, 32'h88AA99BB);
  endtask

  always @(negedge clk) begin
    st_t  s;
    sym_t d;
    if (st_q.size() > 0) begin
      s = st_q.pop_front();
      check("active", active, s.act);
      check("lane_ptr", lane_ptr, s.lp);
      check("out_valid", out_valid, (s.vlane < 0) ? 0 : (1 << s.vlane));
      if (s.chk_zero) check("out_data_zero", out_data, 0);
      if (out_valid != 0) begin
        if (sym_q.size() == 0) check("unexpected_symbol", out_valid, 0);
        else begin
          d = sym_q.pop_front();
          check("symbol_data", out_data[d.lane*WIDTH +: WIDTH], d.data);
        end
      end
    end
  end

  initial begin
    m_t = 0;
    m_win = 0; m_anchor = -1; m_commas = 0; m_locked = 0; m_lane = 0;

    for (int i = 0; i < 6; i++) send_bit(bit'(i % 2), 1'b1);
    send_bit(1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 3; i++) send_sym(COMMA);
    send_sym(8'hFF);
    check("no_lock_after_3bc", active, 0);
    for (int i = 0; i < 4; i++) send_sym(COMMA);
    check("lock_after_4bc", active, 1);

    send_bit(1'b0, 1'b1);
    send_stream();

    send_bit(1'b0, 1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_stream();

    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_sym(COMMA);
    check("relock_active", active, 1);
    check("relock_lane_ptr", lane_ptr, 0);
    send_sym(8'h5A);
    check("relock_lane0_data", out_data[7:0], 8'h5A);

    for (int i = 0; i < 4; i++) send_bit(1'b1);
    send_bit(1'b0, 1'b1);
    send_sym(8'h12, 1'b1);
    send_sym(8'h34, 1'b1);
    check("no_lock_after_reset", active, 0);

    for (int it = 0; it < 20; it++) begin
      int pre;
      int r;
      send_bit(1'b0, 1'b1);
      pre = $urandom_range(0, 7);
      for (int j = 0; j < pre; j++) send_bit(bit'($urandom_range(0, 1)));
      for (int j = 0; j < LOCK_COUNT; j++) send_sym(COMMA);
      for (int k = 0; k < 30; k++) begin
        r = $urandom_range(0, 9);
        if (r < 2) send_sym(COMMA);
        else if (r == 2) begin
          send_bit(bit'($urandom_range(0, 1)));
          send_sym(COMMA);
        end else send_sym(8'($urandom_range(0, 255)));
      end
    end

    repeat (2) @(negedge clk);
    check("status_queue_drained", st_q.size(), 0);
    check("symbol_queue_drained", sym_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
